delay_mixer: RTL and testbench



---
 rtl/delay_mixer_if.sv | 34 +++
 rtl/delay_mixer.sv | 141 ++++++++++++++
 tb/tb_delay_mixer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/delay_mixer_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_mixer_if
// Purpose  : Sample-set handshake bundle between the delay RAM/ADC side, the
//            delay_mixer datapath and the DAC/RAM-write consumer.
// Revision : 1.0  initial release
// ============================================================================
interface delay_mixer_if #(
  parameter int DW = 16,
  parameter int GW = 9
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dry;
  logic [DW-1:0] wet;
  logic [GW-1:0] fb_gain;
  logic [GW-1:0] mix;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] fb_out;
  logic [DW-1:0] mix_out;
  logic          clip;

  modport master (
    output in_valid, dry, wet, fb_gain, mix, out_ready,
    input  in_ready, out_valid, fb_out, mix_out, clip
  );

  modport slave (
    input  in_valid, dry, wet, fb_gain, mix, out_ready,
    output in_ready, out_valid, fb_out, mix_out, clip
  );
endinterface
`default_nettype wire

// File: rtl/delay_mixer.sv
`default_nettype none
// ============================================================================
// Module   : delay_mixer
// Purpose  : Delay-line feedback and dry/wet mixer, time-multiplexed over a
//            single signed multiplier (three multiply cycles per sample).
// Revision : 1.0  initial release
// ============================================================================
module delay_mixer #(
  parameter int DW = 16,
  parameter int GW = 9
) (
  input  wire logic    clk,
  input  wire logic    rst,
  delay_mixer_if.slave bus
);
  localparam int AW = DW + GW + 2;
  localparam int SH = GW - 1;
  localparam logic [GW-1:0] c_unity = {1'b1, {(GW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_P_FB  = 3'd1,
    S_P_DRY = 3'd2,
    S_P_WET = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic signed [DW-1:0] r_dry_s;
  logic signed [DW-1:0] r_wet_s;
  logic [GW-1:0]        r_fb_gain;
  logic [GW-1:0]        r_mix;
  logic signed [AW-1:0] r_acc_fb;
  logic signed [AW-1:0] r_acc_mix;
  logic [DW-1:0]        r_fb_out;
  logic [DW-1:0]        r_mix_out;
  logic                 r_clip;

  logic                 w_accept;
  logic signed [DW-1:0] w_mul_a;
  logic signed [GW:0]   w_mul_b;
  logic signed [AW-1:0] w_prod;
  logic signed [AW-1:0] w_fb_sum;
  logic signed [AW-1:0] w_mix_sum;
  logic [DW-1:0]        w_fb_res;
  logic [DW-1:0]        w_mix_res;
  logic                 w_fb_sat;
  logic                 w_mix_sat;

  function automatic logic [GW-1:0] clamp_gain(input logic [GW-1:0] g);
    return (g > c_unity) ? c_unity : g;
  endfunction

  // Returns {saturated, offset-binary result}; the value fits DW bits only
  // when every bit from the DW-1 position upward is a copy of the sign.
  function automatic logic [DW:0] scale_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sh;
    logic [DW-1:0]        val;
    logic                 sat;
    sh  = acc >>> SH;
    sat = !((&sh[AW-1:DW-1]) || !(|sh[AW-1:DW-1]));
    if (sat)
      val = sh[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      val = sh[DW-1:0];
    return {sat, ~val[DW-1], val[DW-2:0]};
  endfunction

  always_comb begin
    w_accept = bus.in_valid && (r_state == S_IDLE);
    w_next   = r_state;
    w_mul_a  = r_wet_s;
    w_mul_b  = {1'b0, r_fb_gain};
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_P_FB;
      S_P_FB:  w_next = S_P_DRY;
      S_P_DRY: begin
        w_mul_a = r_dry_s;
        w_mul_b = {1'b0, c_unity - r_mix};
        w_next  = S_P_WET;
      end
      S_P_WET: begin
        w_mul_b = {1'b0, r_mix};
        w_next  = S_OUT;
      end
      S_OUT:   if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_prod    = AW'(w_mul_a) * AW'(w_mul_b);
  assign w_fb_sum  = (AW'(r_dry_s) <<< SH) + w_prod;
  assign w_mix_sum = r_acc_mix + w_prod;
  assign {w_fb_sat, w_fb_res}   = scale_sat(r_acc_fb);
  assign {w_mix_sat, w_mix_res} = scale_sat(w_mix_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dry_s   <= '0;
      r_wet_s   <= '0;
      r_fb_gain <= '0;
      r_mix     <= '0;
      r_acc_fb  <= '0;
      r_acc_mix <= '0;
      r_fb_out  <= {1'b1, {(DW-1){1'b0}}};
      r_mix_out <= {1'b1, {(DW-1){1'b0}}};
      r_clip    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_dry_s   <= {~bus.dry[DW-1], bus.dry[DW-2:0]};
          r_wet_s   <= {~bus.wet[DW-1], bus.wet[DW-2:0]};
          r_fb_gain <= clamp_gain(bus.fb_gain);
          r_mix     <= clamp_gain(bus.mix);
        end
        S_P_FB:  r_acc_fb  <= w_fb_sum;
        S_P_DRY: r_acc_mix <= w_prod;
        S_P_WET: begin
          r_acc_mix <= w_mix_sum;
          r_fb_out  <= w_fb_res;
          r_mix_out <= w_mix_res;
          r_clip    <= w_fb_sat | w_mix_sat;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.fb_out    = r_fb_out;
  assign bus.mix_out   = r_mix_out;
  assign bus.clip      = r_clip;
endmodule
`default_nettype wire

// File: tb/tb_delay_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_mixer
// Purpose  : Self-checking bench: directed vector table, reset corner cases and
//            randomized sample sets against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_delay_mixer;
  localparam int DW = 16;
  localparam int GW = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delay_mixer_if #(.DW(DW), .GW(GW)) bus ();
  delay_mixer #(.DW(DW), .GW(GW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] dry;
    logic [15:0] wet;
    logic [8:0]  fbg;
    logic [8:0]  mix;
    logic [15:0] e_fb;
    logic [15:0] e_mix;
    logic        e_clip;
    int          hold;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void sat16(input int a, output logic [15:0] o, output logic s);
    int q;
    q = a >>> 8;
    s = 1'b0;
    if (q > 32767) begin q = 32767; s = 1'b1; end
    else if (q < -32768) begin q = -32768; s = 1'b1; end
    o = 16'(q + 32768);
  endfunction

  function automatic void model(input logic [15:0] d, input logic [15:0] w,
                                input logic [8:0] g, input logic [8:0] m,
                                output logic [15:0] fb, output logic [15:0] mx,
                                output logic c);
    int ds, ws, gg, mm;
    logic s1, s2;
    ds = int'(d) - 32768;
    ws = int'(w) - 32768;
    gg = (g > 9'd256) ? 256 : int'(g);
    mm = (m > 9'd256) ? 256 : int'(m);
    sat16(ds * 256 + ws * gg, fb, s1);
    sat16(ds * (256 - mm) + ws * mm, mx, s2);
    c = s1 | s2;
  endfunction

  task automatic scramble();
    bus.dry     = 16'($urandom);
    bus.wet     = 16'($urandom);
    bus.fb_gain = 9'($urandom);
    bus.mix     = 9'($urandom);
  endtask

  task automatic txn(input string nm, input logic [15:0] d, input logic [15:0] w,
                     input logic [8:0] g, input logic [8:0] m,
                     input logic [15:0] efb, input logic [15:0] emx,
                     input logic ec, input int hold);
    int k;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    check({nm, " in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.dry = d; bus.wet = w; bus.fb_gain = g; bus.mix = m; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      scramble();
      check({nm, " busy_vld_rdy"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    check({nm, " out_valid_rise"}, 64'(bus.out_valid), 64'd1);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      scramble();
      check({nm, " hold_outputs"}, {29'd0, bus.in_ready, bus.out_valid, bus.clip, bus.mix_out, bus.fb_out},
            {29'd0, 1'b0, 1'b1, ec, emx, efb});
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check({nm, " outputs"}, {31'd0, bus.clip, bus.mix_out, bus.fb_out}, {31'd0, ec, emx, efb});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({nm, " back_idle"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    check({nm, " retained"}, {31'd0, bus.clip, bus.mix_out, bus.fb_out}, {31'd0, ec, emx, efb});
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] d, w, efb, emx;
    logic [8:0]  g, m;
    logic        ec;
    bit          seen;

    vecs.push_back('{16'hC000, 16'h8000, 9'd128, 9'd0,   16'hC000, 16'hC000, 1'b0, 0});
    vecs.push_back('{16'h8000, 16'hA000, 9'd128, 9'd256, 16'h9000, 16'hA000, 1'b0, 1});
    vecs.push_back('{16'hC000, 16'h4000, 9'd128, 9'd128, 16'hA000, 16'h8000, 1'b0, 0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 9'd511, 9'd0,   16'hFFFF, 16'hFFFF, 1'b1, 10});
    vecs.push_back('{16'h0000, 16'h0000, 9'd256, 9'd0,   16'h0000, 16'h0000, 1'b1, 2});
    vecs.push_back('{16'h8000, 16'h9000, 9'd0,   9'd511, 16'h8000, 16'h9000, 1'b0, 0});
    vecs.push_back('{16'h8001, 16'h7FFF, 9'd1,   9'd128, 16'h8000, 16'h8000, 1'b0, 0});
    vecs.push_back('{16'h8000, 16'h7FFF, 9'd1,   9'd0,   16'h7FFF, 16'h8000, 1'b0, 1});

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dry = '0; bus.wet = '0; bus.fb_gain = '0; bus.mix = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", {29'd0, bus.in_ready, bus.out_valid, bus.clip, bus.mix_out, bus.fb_out},
          {29'd0, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h8000});

    foreach (vecs[i])
      txn($sformatf("vec%0d", i), vecs[i].dry, vecs[i].wet, vecs[i].fbg, vecs[i].mix,
          vecs[i].e_fb, vecs[i].e_mix, vecs[i].e_clip, vecs[i].hold);

    // Reset landing in P_DRY: previous outputs are non-reset values here.
    bus.dry = 16'hC000; bus.wet = 16'h8000; bus.fb_gain = 9'd128; bus.mix = 9'd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {29'd0, bus.in_ready, bus.out_valid, bus.clip, bus.mix_out, bus.fb_out},
          {29'd0, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h8000});
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_no_out_valid", 64'(seen), 64'd0);

    for (int n = 0; n < 40; n++) begin
      d = 16'($urandom);
      w = 16'($urandom);
      g = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 256));
      m = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 256));
      model(d, w, g, m, efb, emx, ec);
      txn($sformatf("rnd%0d", n), d, w, g, m, efb, emx, ec, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
